mdio_master_axil: RTL and testbench



---
 rtl/mdio_pkg.sv | 36 +++
 rtl/axi_lite_interface.sv | 32 +++
 rtl/mdio_master_axil_clk_gen.sv | 45 ++++
 rtl/mdio_master_axil.sv | 170 +++++++++++++++++
 tb/tb_mdio_master_axil.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, state encoding and frame helpers for the clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_START    = 2'b01;
  localparam logic [1:0] MDIO_TA_WR    = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // AXI address field positions
  localparam int REGAD_LSB    = 0;
  localparam int PHYAD_LSB    = 5;
  localparam int SUPPRESS_BIT = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_WDATA,
    ST_PREAMBLE,
    ST_HEADER,
    ST_TA_WR,
    ST_TA_RD,
    ST_DATA_WR,
    ST_DATA_RD,
    ST_IDLE_BIT,
    ST_RESP
  } mdio_state_t;

  // 14-bit frame header: ST, OP, PHYAD, REGAD, sent MSB first
  function automatic logic [13:0] mdio_header(input logic rd, input logic [4:0] phyad,
                                              input logic [4:0] regad);
    return {MDIO_START, (rd ? MDIO_OP_READ : MDIO_OP_WRITE), phyad, regad};
  endfunction

endpackage

// File: rtl/axi_lite_interface.sv
// Minimal AXI-Lite bundle (32-bit data) with slave and master views.
interface axi_lite_interface #(
  parameter int ADDR_WIDTH = 11
) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport Slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mdio_master_axil_clk_gen.sv
// MDC generator: free-runs only while enabled, idles low, and emits one-clk
// rise/fall strobes in the same cycle mdc changes level.
module mdio_clk_gen #(
  parameter int CLK_DIV = 63
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Half-period counter; restarts and parks mdc low whenever enable drops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      mdc      <= 1'b0;
      mdc_rise <= 1'b0;
      mdc_fall <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
      mdc      <= 1'b0;
      mdc_rise <= 1'b0;
      mdc_fall <= 1'b0;
    end else begin
      mdc_rise <= 1'b0;
      mdc_fall <= 1'b0;
      if (cnt == TERM) begin
        cnt      <= '0;
        mdc      <= ~mdc;
        mdc_rise <= ~mdc;
        mdc_fall <= mdc;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdio_master_axil.sv
// Clause-22 MDIO master behind an AXI-Lite slave. PHYAD/REGAD come from the
// AXI address. Optional build macro MDIO_PREAMBLE_SUPPRESS_EN: when defined,
// address bit 10 set on AR/AW skips the preamble for that transaction.
module mdio_master_axil
  import mdio_pkg::*;
#(
  parameter int CLK_DIV       = 63,
  parameter int PREAMBLE_BITS = 32,
  parameter int ADDR_WIDTH    = 11
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mdio_i,
  output logic mdio_o,
  output logic mdio_t,
  output logic mdc,
  output logic busy,
  axi_lite_interface.Slave axi_lite
);

  localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam bit         NO_PRE   = (PREAMBLE_BITS == 0);

  mdio_state_t state, state_next;
  logic        mdc_rise, mdc_fall;
  logic [5:0]  bit_cnt, cnt_next;
  logic [13:0] hdr_q, hdr_src, hdr_sh;
  logic [15:0] wdata_q, wd_sh, rd_sr;
  logic        is_rd, skip_q, ta_err;
  logic        skip_ar, skip_aw;
  logic        drv_o, drv_t;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [ADDR_WIDTH-1:0] araddr_w, awaddr_w;

  assign araddr_w = axi_lite.araddr;
  assign awaddr_w = axi_lite.awaddr;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign skip_ar = NO_PRE | araddr_w[SUPPRESS_BIT];
  assign skip_aw = NO_PRE | awaddr_w[SUPPRESS_BIT];
  logic unused_bits;
  assign unused_bits = ^{axi_lite.wstrb, axi_lite.wdata[31:16]};
`else
  assign skip_ar = NO_PRE;
  assign skip_aw = NO_PRE;
  logic unused_bits;
  assign unused_bits = ^{axi_lite.wstrb, axi_lite.wdata[31:16],
                         araddr_w[SUPPRESS_BIT], awaddr_w[SUPPRESS_BIT]};
`endif

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (busy),
    .mdc     (mdc),
    .mdc_rise(mdc_rise),
    .mdc_fall(mdc_fall)
  );

  function automatic logic in_frame(input mdio_state_t s);
    return (s == ST_PREAMBLE) || (s == ST_HEADER) || (s == ST_TA_WR) || (s == ST_TA_RD) ||
           (s == ST_DATA_WR) || (s == ST_DATA_RD) || (s == ST_IDLE_BIT);
  endfunction

  // AXI handshake signals follow directly from the FSM state
  assign axi_lite.awready = (state == ST_IDLE);
  assign axi_lite.arready = (state == ST_IDLE);
  assign axi_lite.wready  = (state == ST_WAIT_WDATA);
  assign axi_lite.bvalid  = (state == ST_RESP) && !is_rd;
  assign axi_lite.rvalid  = (state == ST_RESP) && is_rd;
  assign axi_lite.bresp   = AXI_RESP_OKAY;
  assign axi_lite.rresp   = rresp_q;
  assign axi_lite.rdata   = rdata_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state: bit phases advance on MDC fall strobes; reads win address ties
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (axi_lite.arvalid)      state_next = skip_ar ? ST_HEADER : ST_PREAMBLE;
        else if (axi_lite.awvalid) state_next = ST_WAIT_WDATA;
      end
      ST_WAIT_WDATA: if (axi_lite.wvalid) state_next = skip_q ? ST_HEADER : ST_PREAMBLE;
      ST_PREAMBLE:   if (mdc_fall && bit_cnt == PRE_LAST) state_next = ST_HEADER;
      ST_HEADER:     if (mdc_fall && bit_cnt == 6'd13) state_next = is_rd ? ST_TA_RD : ST_TA_WR;
      ST_TA_WR:      if (mdc_fall && bit_cnt == 6'd1) state_next = ST_DATA_WR;
      ST_TA_RD:      if (mdc_fall && bit_cnt == 6'd1) state_next = ST_DATA_RD;
      ST_DATA_WR,
      ST_DATA_RD:    if (mdc_fall && bit_cnt == 6'd15) state_next = ST_IDLE_BIT;
      ST_IDLE_BIT:   if (mdc_fall) state_next = ST_RESP;
      ST_RESP: begin
        if (is_rd ? axi_lite.rready : axi_lite.bready) state_next = ST_IDLE;
      end
      default:       state_next = ST_IDLE;
    endcase
  end

  // Bit index for the upcoming cycle and the pad value for the bit it selects
  always_comb begin
    cnt_next = bit_cnt;
    if (state_next != state) cnt_next = '0;
    else if (mdc_fall)       cnt_next = bit_cnt + 6'd1;
    hdr_src = (state == ST_IDLE) ? mdio_header(1'b1, araddr_w[PHYAD_LSB +: 5],
                                               araddr_w[REGAD_LSB +: 5]) : hdr_q;
    hdr_sh  = hdr_src << cnt_next;
    wd_sh   = wdata_q << cnt_next;
    drv_o   = 1'b0;
    drv_t   = 1'b1;
    case (state_next)
      ST_PREAMBLE: begin drv_o = 1'b1;      drv_t = 1'b0; end
      ST_HEADER:   begin drv_o = hdr_sh[13]; drv_t = 1'b0; end
      ST_TA_WR:    begin drv_o = cnt_next[0] ? MDIO_TA_WR[0] : MDIO_TA_WR[1]; drv_t = 1'b0; end
      ST_DATA_WR:  begin drv_o = wd_sh[15]; drv_t = 1'b0; end
      default:     begin drv_o = 1'b0;      drv_t = 1'b1; end
    endcase
  end

  // Control: pad drive on entry/fall, transaction latches, TA check, response capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      mdio_o  <= 1'b0;
      mdio_t  <= 1'b1;
      busy    <= 1'b0;
      is_rd   <= 1'b0;
      skip_q  <= 1'b0;
      ta_err  <= 1'b0;
      hdr_q   <= '0;
      rdata_q <= '0;
      rresp_q <= AXI_RESP_OKAY;
    end else begin
      bit_cnt <= cnt_next;
      busy    <= in_frame(state_next);
      if (state_next != state || mdc_fall) begin
        mdio_o <= drv_o;
        mdio_t <= drv_t;
      end
      if (state == ST_IDLE) begin
        if (axi_lite.arvalid) begin
          is_rd  <= 1'b1;
          ta_err <= 1'b0;
          hdr_q  <= mdio_header(1'b1, araddr_w[PHYAD_LSB +: 5], araddr_w[REGAD_LSB +: 5]);
        end else if (axi_lite.awvalid) begin
          is_rd  <= 1'b0;
          skip_q <= skip_aw;
          hdr_q  <= mdio_header(1'b0, awaddr_w[PHYAD_LSB +: 5], awaddr_w[REGAD_LSB +: 5]);
        end
      end
      if (mdc_rise && state == ST_TA_RD && bit_cnt == 6'd1) ta_err <= mdio_i;
      if (state == ST_IDLE_BIT && state_next == ST_RESP && is_rd) begin
        rdata_q <= {16'h0000, rd_sr};
        rresp_q <= ta_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  // Data path: write payload latch and read shift register (no reset needed)
  always_ff @(posedge clk) begin
    if (state == ST_WAIT_WDATA && axi_lite.wvalid) wdata_q <= axi_lite.wdata[15:0];
    if (mdc_rise && state == ST_DATA_RD) rd_sr <= {rd_sr[14:0], mdio_i};
  end

endmodule

// File: tb/tb_mdio_master_axil.sv
// Scoreboard bench for mdio_master_axil: AXI stimulus pushes expected
// responses, a monitor pops and compares on each B/R handshake, and a PHY
// model captures the MDIO frame and answers reads.
module tb_mdio_master_axil;

  localparam int CLK_DIV = 4;
  localparam int PRE     = 32;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int SUPP_PRE = 0;
`else
  localparam int SUPP_PRE = 32;
`endif

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    logic [1:0]  resp;
    int          pre;
    logic [13:0] hdr;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mdio_i = 1'b1;
  logic mdio_o, mdio_t, mdc, busy;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  bit          phy_present = 1'b0;
  logic [15:0] phy_data = '0;
  int          cur_pre = PRE;
  int          rise_cnt = 0;
  logic        cap_o [0:127];
  logic        cap_t [0:127];

  always #5 clk = ~clk;

  axi_lite_interface #(.ADDR_WIDTH(11)) axi ();

  mdio_master_axil #(.CLK_DIV(CLK_DIV), .PREAMBLE_BITS(PRE), .ADDR_WIDTH(11)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mdio_i  (mdio_i),
    .mdio_o  (mdio_o),
    .mdio_t  (mdio_t),
    .mdc     (mdc),
    .busy    (busy),
    .axi_lite(axi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", tag);
  endtask

  function automatic logic [13:0] hdr_of(input bit rd, input logic [10:0] a);
    return {2'b01, (rd ? 2'b10 : 2'b01), a[9:5], a[4:0]};
  endfunction

  // PHY side: bit k of the frame is sampled on rise k+1; drive it after the previous fall
  function automatic logic phy_bit(input int k);
    logic [15:0] sh;
    if (phy_present && k == cur_pre + 15) return 1'b0;
    if (phy_present && k >= cur_pre + 16 && k < cur_pre + 32) begin
      sh = phy_data << (k - cur_pre - 16);
      return sh[15];
    end
    return 1'b1;
  endfunction

  always @(posedge mdc) begin
    if (rise_cnt < 128) begin
      cap_o[rise_cnt] = mdio_o;
      cap_t[rise_cnt] = mdio_t;
    end
    rise_cnt++;
  end

  always @(negedge mdc) mdio_i = phy_bit(rise_cnt);

  // Response monitor: compare each handshake against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [13:0] h;
    logic [15:0] wd;
    int          drv, ones, rel;
    if ((axi.rvalid && axi.rready) || (axi.bvalid && axi.bready)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: response seen with empty scoreboard");
      end else begin
        e = sb.pop_front();
        check("resp_kind", axi.rvalid, e.is_rd);
        if (e.is_rd) begin
          check("rdata", axi.rdata, {16'h0000, e.data});
          check("rresp", axi.rresp, e.resp);
        end else begin
          check("bresp", axi.bresp, e.resp);
        end
        check("mdc_rises", rise_cnt, e.pre + 33);
        ones = 0;
        for (int i = 0; i < e.pre; i++) if (cap_o[i] === 1'b1 && cap_t[i] === 1'b0) ones++;
        check("preamble_ones", ones, e.pre);
        h = '0;
        drv = 0;
        for (int i = 0; i < 14; i++) begin
          h = {h[12:0], cap_o[e.pre + i]};
          if (cap_t[e.pre + i] === 1'b0) drv++;
        end
        check("header", h, e.hdr);
        check("header_driven", drv, 14);
        if (e.is_rd) begin
          rel = 0;
          for (int i = 14; i < 33; i++) if (cap_t[e.pre + i] === 1'b1) rel++;
          check("rd_released", rel, 19);
        end else begin
          check("wr_ta", {cap_o[e.pre + 14], cap_o[e.pre + 15], cap_t[e.pre + 14],
                          cap_t[e.pre + 15]}, 4'b1000);
          wd = '0;
          for (int i = 0; i < 16; i++) wd = {wd[14:0], cap_o[e.pre + 16 + i]};
          check("wr_data", wd, e.data);
        end
      end
      rise_cnt = 0;
    end
  end

  // ch: 0 = AR, 1 = AW, 2 = W
  task automatic send(input int ch, input logic [31:0] v);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    case (ch)
      0: begin axi.araddr = v[10:0]; axi.arvalid = 1'b1; end
      1: begin axi.awaddr = v[10:0]; axi.awvalid = 1'b1; end
      default: begin axi.wdata = v; axi.wstrb = 4'h0; axi.wvalid = 1'b1; end
    endcase
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (ch == 0) ? axi.arready : (ch == 1) ? axi.awready : axi.wready;
      @(posedge clk);
    end
    #1;
    axi.arvalid = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    if (!ok) fail_now("addr_data_accept");
  endtask

  task automatic accept_resp(input int hold, output int aw_hi);
    bit got = 1'b0;
    int n = 0;
    aw_hi = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (axi.rvalid || axi.bvalid) got = 1'b1;
      else if (axi.awready) aw_hi++;
    end
    if (!got) begin
      fail_now("resp_timeout");
      return;
    end
    repeat (hold) begin
      @(negedge clk);
      if (axi.rvalid || axi.bvalid) n++;
    end
    check("valid_held", n, hold);
    @(posedge clk);
    #1;
    axi.rready = 1'b1;
    axi.bready = 1'b1;
    @(posedge clk);
    #1;
    axi.rready = 1'b0;
    axi.bready = 1'b0;
    @(negedge clk);
    check("ready_after_resp", {axi.awready, axi.arready}, 2'b11);
  endtask

  task automatic push_exp(input bit rd, input logic [10:0] a, input logic [15:0] d,
                          input logic [1:0] resp, input int pre);
    exp_t e;
    e.is_rd = rd;
    e.data  = d;
    e.resp  = resp;
    e.pre   = pre;
    e.hdr   = hdr_of(rd, a);
    sb.push_back(e);
  endtask

  task automatic do_read(input logic [10:0] a, input bit present, input logic [15:0] d,
                         input int pre);
    int aw_hi;
    phy_present = present;
    phy_data    = d;
    cur_pre     = pre;
    push_exp(1'b1, a, present ? d : 16'hFFFF, present ? 2'b00 : 2'b10, pre);
    send(0, {21'h0, a});
    @(negedge clk);
    check("busy_rd", busy, 1'b1);
    accept_resp(2, aw_hi);
    @(negedge clk);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin : stim
    int aw_hi;
    int n;
    bit hit;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {axi.awready, axi.arready, axi.wready}, 3'b110);
    check("rst_valid", {axi.bvalid, axi.rvalid}, 2'b00);
    check("rst_pads", {mdc, mdio_o, mdio_t, busy}, 4'b0010);
    check("rst_rdata", axi.rdata, 32'h0);
    check("rst_resp", {axi.bresp, axi.rresp}, 4'b0000);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Read PHY 0x0C reg 2
    do_read(11'h182, 1'b1, 16'h2000, PRE);

    // Write PHY 0x0C reg 0 with wdata two cycles after the address
    phy_present = 1'b0;
    cur_pre = PRE;
    push_exp(1'b0, 11'h180, 16'h1140, 2'b00, PRE);
    send(1, 32'h180);
    @(negedge clk);
    check("wready_after_aw", axi.wready, 1'b1);
    repeat (2) @(posedge clk);
    send(2, 32'h0000_1140);
    accept_resp(3, aw_hi);

    // Read with nobody answering
    do_read(11'h1E5, 1'b0, 16'h0000, PRE);

    // Same-cycle AR and AW: read first, write held off until after R handshake
    phy_present = 1'b1;
    phy_data    = 16'h55AA;
    cur_pre     = PRE;
    push_exp(1'b1, 11'h043, 16'h55AA, 2'b00, PRE);
    push_exp(1'b0, 11'h061, 16'hA5A5, 2'b00, PRE);
    @(posedge clk);
    #1;
    axi.araddr = 11'h043; axi.arvalid = 1'b1;
    axi.awaddr = 11'h061; axi.awvalid = 1'b1;
    @(posedge clk);
    #1 axi.arvalid = 1'b0;
    accept_resp(1, aw_hi);
    check("aw_blocked_during_read", aw_hi, 0);
    @(posedge clk);
    #1 axi.awvalid = 1'b0;
    phy_present = 1'b0;
    @(negedge clk);
    check("wready_tie", axi.wready, 1'b1);
    send(2, 32'h0000_A5A5);
    accept_resp(1, aw_hi);

    // Reset pulse in the middle of the write data phase
    cur_pre = PRE;
    push_exp(1'b0, 11'h1A3, 16'hBEEF, 2'b00, PRE);
    send(1, 32'h1A3);
    send(2, 32'h0000_BEEF);
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = (rise_cnt >= PRE + 20);
    end
    if (!hit) fail_now("reach_data_wr");
    #2 reset_n = 1'b0;
    #1;
    check("abort_pads", {mdc, mdio_t, busy}, 3'b010);
    void'(sb.pop_back());
    rise_cnt = 0;
    mdio_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (axi.bvalid || axi.rvalid) n++;
    end
    check("no_resp_after_abort", n, 0);

    // Normal read after the abort
    do_read(11'h0A1, 1'b1, 16'h7A5C, PRE);

    // Preamble suppress bit in the address
    do_read(11'h582, 1'b1, 16'h1234, SUPP_PRE);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
